// File: rtl/ntt_pkg.sv
// ============================================================================
//  Module      : ntt_pkg
//  Description : Shared types and constants for the NTT PE sequencer:
//                sequencer state encoding, default transform size / latency,
//                transform-mode encodings and a stage-counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ntt_pkg;

    localparam int DEF_LOGN = 8;
    localparam int DEF_LAT  = 3;

    localparam logic MODE_NTT  = 1'b0;
    localparam logic MODE_INTT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    // Width needed to hold a stage number 0..logn-1 (never below one bit).
    function automatic int stage_w(input int logn);
        return (logn > 1) ? $clog2(logn) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_addr_gen.sv
// ============================================================================
//  Module      : ntt_addr_gen
//  Description : Combinational butterfly address generator. Maps the
//                (mode, stage, butterfly) triple onto the two coefficient
//                addresses and the twiddle index. Both NTT and INTT reduce to
//                the same form once the half-span exponent is chosen:
//                  a = (k / m) * 2m + (k mod m), b = a + m,
//                  twiddle = N/(2m) + k / m.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int LOGN = DEF_LOGN,
    parameter int SW   = stage_w(LOGN)
) (
    input  logic            mode,
    input  logic [SW-1:0]   s,
    input  logic [LOGN-1:0] k,
    output logic [LOGN-1:0] addr_a,
    output logic [LOGN-1:0] addr_b,
    output logic [LOGN-1:0] tw_idx
);

    logic [SW-1:0]   w_mlog;
    logic [LOGN-1:0] w_m;
    logic [LOGN-1:0] w_j;
    logic [LOGN-1:0] w_g;

    // Half-span exponent selects the butterfly geometry for this stage.
    always_comb begin
        w_mlog = (mode == MODE_NTT) ? (SW'(LOGN - 1) - s) : s;
        w_m    = LOGN'(1) << w_mlog;
        w_j    = k & (w_m - LOGN'(1));
        w_g    = k >> w_mlog;
        addr_a = ((w_g << w_mlog) << 1) | w_j;
        addr_b = addr_a | w_m;
        tw_idx = (LOGN'(1) << (SW'(LOGN - 1) - w_mlog)) + w_g;
    end

endmodule

`default_nettype wire

// File: rtl/ntt_pe_sequencer.sv
// ============================================================================
//  Module      : ntt_pe_sequencer
//  Description : Stage/butterfly sequencer for a radix-2 NTT/INTT PE pair.
//                Issues one butterfly per cycle across all LOGN stages,
//                drains LAT cycles between stages, and delays the read
//                strobe/addresses by LAT cycles to form the write-back.
//                Optional feature macro NTT_SEQ_HOLD_EN adds a 'hold' input
//                that freezes issue while in RUN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntt_pe_sequencer
    import ntt_pkg::*;
#(
    parameter int LOGN = DEF_LOGN,
    parameter int LAT  = DEF_LAT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
`ifdef NTT_SEQ_HOLD_EN
    input  logic            hold,
`endif
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN:0]   tf_addr,
    output logic            pe_inv,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int SW = stage_w(LOGN);
    localparam int DW = $clog2(LAT + 1);
    localparam logic [LOGN-1:0] KLAST = LOGN'((1 << (LOGN - 1)) - 1);

    seq_state_t      r_state;
    seq_state_t      w_next;
    logic [SW-1:0]   r_s;
    logic [LOGN-1:0] r_k;
    logic [DW-1:0]   r_d;
    logic            r_mode;
    logic            w_hold;
    logic            w_run;
    logic [LOGN-1:0] w_a;
    logic [LOGN-1:0] w_b;
    logic [LOGN-1:0] w_idx;

    logic            r_dly_en [LAT];
    logic [LOGN-1:0] r_dly_a  [LAT];
    logic [LOGN-1:0] r_dly_b  [LAT];

`ifdef NTT_SEQ_HOLD_EN
    assign w_hold = hold;
`else
    assign w_hold = 1'b0;
`endif

    ntt_addr_gen #(
        .LOGN (LOGN),
        .SW   (SW)
    ) u_addr_gen (
        .mode   (r_mode),
        .s      (r_s),
        .k      (r_k),
        .addr_a (w_a),
        .addr_b (w_b),
        .tw_idx (w_idx)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode and control outputs; addresses are zero outside RUN.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        rd_en  = 1'b0;
        w_run  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_RUN;
            end
            ST_RUN: begin
                busy  = 1'b1;
                w_run = 1'b1;
                rd_en = !w_hold;
                if (!w_hold && (r_k == KLAST)) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (r_d == DW'(LAT - 1))
                    w_next = (r_s == SW'(LOGN - 1)) ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        rd_addr_a = w_run ? w_a : '0;
        rd_addr_b = w_run ? w_b : '0;
        tf_addr   = w_run ? {r_mode, w_idx} : '0;
    end

    assign pe_inv = r_mode;

    // Stage, butterfly and drain counters plus the mode latched at start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s    <= '0;
            r_k    <= '0;
            r_d    <= '0;
            r_mode <= MODE_NTT;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_s    <= '0;
                        r_k    <= '0;
                        r_d    <= '0;
                        r_mode <= mode;
                    end
                end
                ST_RUN: begin
                    r_d <= '0;
                    if (!w_hold) r_k <= (r_k == KLAST) ? '0 : r_k + LOGN'(1);
                end
                ST_DRAIN: begin
                    if (r_d == DW'(LAT - 1)) begin
                        r_d <= '0;
                        if (r_s != SW'(LOGN - 1)) r_s <= r_s + SW'(1);
                    end else begin
                        r_d <= r_d + DW'(1);
                    end
                end
                default: begin
                    r_s <= '0;
                    r_k <= '0;
                    r_d <= '0;
                end
            endcase
        end
    end

    // Write-back delay line: read strobe and addresses shifted LAT cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                r_dly_en[i] <= 1'b0;
                r_dly_a[i]  <= '0;
                r_dly_b[i]  <= '0;
            end
        end else begin
            r_dly_en[0] <= rd_en;
            r_dly_a[0]  <= rd_addr_a;
            r_dly_b[0]  <= rd_addr_b;
            for (int i = 1; i < LAT; i++) begin
                r_dly_en[i] <= r_dly_en[i-1];
                r_dly_a[i]  <= r_dly_a[i-1];
                r_dly_b[i]  <= r_dly_b[i-1];
            end
        end
    end

    assign wr_en     = r_dly_en[LAT-1];
    assign wr_addr_a = r_dly_a[LAT-1];
    assign wr_addr_b = r_dly_b[LAT-1];

endmodule

`default_nettype wire

// File: doc/ntt_pe_sequencer.md
# ntt_pe_sequencer

Stage/butterfly sequencer for a radix-2 NTT/INTT datapath built from a pair of `ntt_intt_pe_cell` instances: one with `sub`=0 and one with `sub`=1.
- On `start` it walks all LOGN stages of an N=2^LOGN-point transform and issues one butterfly per cycle.
- For each butterfly it generates the coefficient-RAM read addresses, the twiddle-ROM address and the PE `inv` control.
- It delays the addresses to produce matching write-back strobes.
- It sits between the top-level control FSM and the coefficient RAM / twiddle ROM / PE pair.

## Interface
Parameters:
- LOGN, 8, log2 of transform length N
- LAT, 3, cycles from `rd_en` to the matching `wr_en` (RAM read + PE + modred pipeline), ≥1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin transform; sampled only in IDLE
- mode  in  1  0 = NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande); latched at start
- busy  out  1  high from the first RUN cycle through the DONE cycle
- done  out  1  one-cycle pulse at end of transform
- rd_en  out  1  butterfly issue strobe
- rd_addr_a, rd_addr_b  out  LOGN  coefficient read addresses
- tf_addr  out  LOGN+1  twiddle ROM address {mode, index}
- pe_inv  out  1  drives PE `inv`; equals latched mode
- wr_en  out  1  `rd_en` delayed LAT cycles
- wr_addr_a, wr_addr_b  out  LOGN  read addresses delayed LAT cycles
- hold  in  1  issue freeze (present only with NTT_SEQ_HOLD_EN)

## Operation
States:
- IDLE: `start`=1 → RUN, with stage s=0 and butterfly k=0; mode is latched.
- RUN: `rd_en`=1. k increments each cycle. At k=N/2-1 → DRAIN and k clears.
- DRAIN: LAT cycles with `rd_en`=0, so stage s writes land before stage s+1 reads. When the drain ends: if s<LOGN-1 then s++ → RUN, else → DONE.
- DONE: `done`=1 for one cycle → IDLE.

Address rules (all addresses computed from s and k):
- NTT: m = 2^(LOGN-1-s). INTT: m = 2^s.
- j = k mod m, g = k / m.
- a = g·2m + j, b = a + m.
- NTT twiddle index = 2^s + g. INTT twiddle index = 2^(LOGN-1-s) + g.
- `tf_addr` = {mode, index}. Index 0 is never issued.

Control and boundary behaviour:
- `pe_inv` = latched mode, held constant for the whole transform.
- `start` while busy is ignored. `mode` changes while busy are ignored.
- Reset in any state: return to IDLE, s=k=0, and clear the delay line. In-flight writes are discarded (no `wr_en` after reset).
- Reset values: all outputs are 0.

## Timing
- Cycle 0: `start`=1 seen in IDLE. Cycle 1: first RUN cycle, `rd_en`=1.
- `wr_en` / `wr_addr_*` at cycle t+LAT equal `rd_en` / `rd_addr_*` at cycle t.
- `done` is high at cycle 1 + LOGN·(N/2+LAT). For LOGN=3, LAT=3 that is cycle 22.
- The last `wr_en` occurs in the final DRAIN cycle, before `done`.
- A new `start` is accepted in the cycle after `done`.

## Configuration
- NTT_SEQ_HOLD_EN defined:
  - `hold` port exists.
  - While `hold`=1 in RUN: `rd_en`=0 and s, k and the addresses freeze.
  - The delay line keeps shifting, so earlier issues still write back.
  - `hold` is ignored in IDLE/DRAIN/DONE.
  - Each held cycle extends the `done` time by one.
- NTT_SEQ_HOLD_EN undefined: no `hold` port, and RUN never stalls.

## Structure
- Shared package `ntt_pkg`:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - default LOGN/LAT constants
  - mode encodings NTT=0 / INTT=1
- Sub-module `ntt_addr_gen`: combinational; maps (mode, s, k) to (a, b, twiddle index).
- The `rd_en`/address delay line is a LAT-deep shift register inside the top module.

## Test plan
All scenarios use LOGN=3, LAT=3.
- NTT sweep: start, mode=0 → issues in order:
  - s0: (0,4), (1,5), (2,6), (3,7), all tf 1
  - s1: (0,2) tf2, (1,3) tf2, (4,6) tf3, (5,7) tf3
  - s2: (0,1)tf4, (2,3)tf5, (4,5)tf6, (6,7)tf7
  - `pe_inv`=0 throughout; `done` at cycle 22.
- INTT sweep: mode=1 → issues in order:
  - s0: (0,1)tf12, (2,3)tf13, (4,5)tf14, (6,7)tf15
  - s1: (0,2)tf10, (1,3)tf10, (4,6)tf11, (5,7)tf11
  - s2: pairs (j, j+4) all tf9
  - `pe_inv`=1.
- Write-back alignment: each `wr_en`/`wr_addr_*` pair matches `rd_*` from exactly 3 cycles earlier. There is no read of stage s+1 before the last stage-s write.
- Busy/start: `start` pulsed at cycle 5 and again at the `done` cycle → both ignored. `start` the cycle after `done` → new run with `rd_en` 1 cycle later.
- Reset mid-run: `rst_n`=0 at cycle 10 → next cycle all outputs 0, state IDLE, and no `wr_en` afterwards.
- Hold (NTT_SEQ_HOLD_EN): `hold`=1 for cycles 3–4 → addresses frozen at k=2, `rd_en`=0 during hold, `done` at cycle 24.
